// File: rtl/adc_serial_capture.sv
`default_nettype none
// ============================================================================
// Module  : adc_serial_capture
// Brief   : SPI-style ADC front end; drives CS/SCLK, deserialises MSB-first
//           conversions into words with a valid strobe and a frame counter.
// Rev     : 1.0
// ============================================================================
module adc_serial_capture #(
  parameter int CLK_DIV   = 2,
  parameter int DATA_BITS = 16,
  parameter int CONV_GAP  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_in,
  input  logic                 sdata_in,
  output logic                 sclk_out,
  output logic                 cs_n_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid_out,
  output logic                 busy_out,
  output logic [15:0]          sample_count_out
);

  localparam int DIV_MAX = (CLK_DIV > CONV_GAP) ? CLK_DIV : CONV_GAP;
  localparam int CNT_W   = $clog2(DIV_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CONV_GAP - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   sclk_q, sclk_d;
  logic                   cs_n_q, cs_n_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [15:0]            sample_count_q, sample_count_d;
  logic                   w_div_end;

  assign w_div_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      div_q          <= '0;
      bit_q          <= '0;
      sclk_q         <= 1'b1;
      cs_n_q         <= 1'b1;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      shift_q        <= '0;
      data_q         <= '0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      div_q          <= div_d;
      bit_q          <= bit_d;
      sclk_q         <= sclk_d;
      cs_n_q         <= cs_n_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
      shift_q        <= shift_d;
      data_q         <= data_d;
      sample_count_q <= sample_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    div_d          = div_q;
    bit_d          = bit_q;
    sclk_d         = sclk_q;
    cs_n_d         = cs_n_q;
    busy_d         = busy_q;
    valid_d        = 1'b0;
    shift_d        = shift_q;
    data_d         = data_q;
    sample_count_d = sample_count_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b1;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        div_d  = '0;
        if (enable_in) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_SETUP: begin
        if (w_div_end) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (w_div_end) begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising SCLK edge: the ADC's bit has been stable for a full low half.
            sclk_d  = 1'b1;
            shift_d = {shift_q[DATA_BITS-2:0], sdata_in};
            if (bit_q == BIT_LAST) begin
              state_d = S_HOLD;
            end
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (w_div_end) begin
          state_d        = S_GAP;
          cs_n_d         = 1'b1;
          div_d          = '0;
          data_d         = shift_q;
          valid_d        = 1'b1;
          sample_count_d = sample_count_q + 16'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d = '0;
          if (enable_in) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b1;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        div_d   = '0;
      end
    endcase
  end

  assign sclk_out         = sclk_q;
  assign cs_n_out         = cs_n_q;
  assign data_out         = data_q;
  assign data_valid_out   = valid_q;
  assign busy_out         = busy_q;
  assign sample_count_out = sample_count_q;

endmodule
`default_nettype wire

// File: doc/adc_serial_capture.md
Name: adc_serial_capture

Overview:
- Serial ADC front end for the oscilloscope channel.
- Generates chip-select and serial clock for an external SPI-style ADC (MSB first, data changes on SCLK falling edge) and deserialises each conversion into a 16-bit word.
- Presents each word with a one-cycle valid strobe. The word feeds the downstream scale/offset/coupling stage through its 16-bit data input.
- Also keeps a running sample counter for the capture/trigger logic.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk cycles; legal range is 1 or more.
- DATA_BITS, 16, bits per conversion; also the width of data_out.
- CONV_GAP, 4, cs_n_out high time between back-to-back frames, in clk cycles; legal range is 2 or more.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- enable_in  input  1  level; while high, conversions run back-to-back.
- sdata_in  input  1  serial data from the ADC.
- sclk_out  output  1  serial clock to the ADC; idles high.
- cs_n_out  output  1  chip select to the ADC, active low.
- data_out  output  DATA_BITS  last complete conversion; holds until the next frame completes.
- data_valid_out  output  1  one-cycle strobe; data_out is new in this cycle.
- busy_out  output  1  high from cs_n_out fall until the end of the gap.
- sample_count_out  output  16  count of completed frames; wraps from 0xFFFF to 0.

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs are registered.
  - Reset is asynchronous and active-high, and may assert at any time, including mid-frame. On assertion all outputs take their reset values immediately and the FSM returns to IDLE. A partial frame is discarded, and it produces no valid strobe and no count increment.
- Reset values: sclk_out=1, cs_n_out=1, data_out=0, data_valid_out=0, busy_out=0, sample_count_out=0, FSM=IDLE.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: cs_n_out=1, sclk_out=1. If enable_in=1 in a cycle, the next cycle enters SETUP with cs_n_out=0 and busy_out=1.
  - SETUP: CLK_DIV cycles with sclk_out=1, then enter SHIFT.
  - SHIFT: DATA_BITS bit periods. Each bit period is CLK_DIV cycles with sclk_out=0, then CLK_DIV cycles with sclk_out=1.
    - sdata_in is sampled into the shift register on the clk edge that drives sclk_out 0->1.
    - Bits are shifted MSB first, into bit 0 with a left shift.
  - HOLD: there is no separate HOLD half-period. The high half of the last bit period serves as hold time. When it ends, the next cycle has cs_n_out=1, and the FSM enters GAP.
  - GAP, first cycle:
    - data_out is loaded with the shift register.
    - data_valid_out=1.
    - sample_count_out increments.
  - GAP length and exit:
    - GAP lasts CONV_GAP cycles with cs_n_out=1.
    - In the last GAP cycle, if enable_in=1 the next cycle enters SETUP (cs_n_out falls). Otherwise the FSM enters IDLE and busy_out drops.
- Frame timing:
  - cs_n_out is low for exactly (2*DATA_BITS+1)*CLK_DIV cycles.
  - With enable_in held high, the conversion period is (2*DATA_BITS+1)*CLK_DIV + CONV_GAP cycles. With defaults this is 70 cycles.
  - busy_out is low for only one cycle between back-to-back frames: no.
- enable_in handling:
  - enable_in is sampled only in IDLE and in the last GAP cycle.
  - Deasserting it mid-frame never truncates a frame; the frame completes and its strobe is issued.
  - A one-cycle enable_in pulse in IDLE produces exactly one frame.
- Simultaneous events:
  - A valid strobe coincident with rst assertion is suppressed by reset.
  - A sample_count_out wrap coincides with a normal valid strobe.
- No data widening or arithmetic: data_out is raw ADC code. Scaling and offset are the downstream stage's job.

Test Plan:
- Reset, idle and single frame:
  - Stimulus: after reset, enable_in low for 20 cycles.
  - Required: sclk_out=1, cs_n_out=1, data_valid_out=0 and sample_count_out=0 throughout.
  - Stimulus: pulse enable_in for 1 cycle, while an ADC model drives 16'hA5C3 MSB first (changing on SCLK falling edges).
  - Required: cs_n_out low for exactly 66 cycles, exactly 16 sclk_out rising edges, then one data_valid_out pulse with data_out=16'hA5C3 and sample_count_out=1, then return to IDLE.
- Continuous run:
  - Stimulus: enable_in held high; the model returns 0x0000, 0xFFFF, 0x8001 and 0x1234 in sequence.
  - Required: data_out matches each word in order, valid pulses are spaced exactly 70 cycles apart, and cs_n_out is high for exactly 4 cycles between frames.
- Enable dropped mid-frame:
  - Stimulus: deassert enable_in at bit 5 of a frame.
  - Required: the frame completes with the correct word and one valid pulse, and no further cs_n_out fall occurs.
- Reset mid-frame:
  - Stimulus: assert rst asynchronously at bit 9.
  - Required: outputs reach their reset values without waiting for a clk edge, and no valid pulse occurs. The count is unchanged at 0.
  - Stimulus: the next enable_in.
  - Required: a full, correct frame.
- Counter wrap and parameter sweep:
  - Stimulus: force the count to 0xFFFE and run 2 frames.
  - Required: sample_count_out goes 0xFFFF, then 0x0000, with a valid pulse each time.
  - Stimulus: repeat the single-frame check with CLK_DIV=1, CONV_GAP=2.
  - Required: cs_n_out low for 33 cycles and a period of 35 cycles.
